// File: rtl/edge_event_pkg.sv
// Shared constants and helpers for the edge event capture block.
package edge_event_pkg;

  // Per-channel edge select encodings
  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // Debounce counter width: enough bits to hold DEBOUNCE_CYCLES, never below 1
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/edge_event_capture_chan.sv
// One channel: synchroniser, debounce filter, edge qualification and sticky pending flag.
module edge_event_chan
  import edge_event_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          RESET_LEVEL     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din_i,
  input  logic [1:0] mode_i,
  input  logic       clr_i,
  output logic       level_o,
  output logic       pulse_o,
  output logic       pending_o
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   pending_q, pending_d;
  logic                   s_out;
  logic                   is_rise;
  logic                   is_fall;

  // Next-state: shift synchroniser, count disagreeing samples, qualify edges, update pending
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], din_i};
    s_out   = sync_q[SYNC_STAGES-1];
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
    if (s_out != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = s_out;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    is_rise = level_d & ~level_q;
    is_fall = ~level_d & level_q;

    case (mode_i)
      EDGE_RISE: pulse_d = is_rise;
      EDGE_FALL: pulse_d = is_fall;
      EDGE_BOTH: pulse_d = is_rise | is_fall;
      default:   pulse_d = 1'b0;
    endcase

    // A same-cycle set beats a clear so no event is lost
    pending_d = (pending_q & ~clr_i) | pulse_d;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q     <= '0;
      level_q   <= RESET_LEVEL;
      pulse_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
    end
  end

  assign level_o   = level_q;
  assign pulse_o   = pulse_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/edge_event_capture.sv
// Multi-channel input event conditioner with combined interrupt request.
module edge_event_capture
  import edge_event_pkg::*;
#(
  parameter int unsigned NCH             = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          RESET_LEVEL     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   din,
  input  logic [2*NCH-1:0] mode,
  input  logic [NCH-1:0]   clr,
  output logic [NCH-1:0]   level,
  output logic [NCH-1:0]   pulse,
  output logic [NCH-1:0]   pending,
  output logic             irq
);

  // Independent per-channel conditioners
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    edge_event_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .din_i    (din[i]),
      .mode_i   (mode[2*i +: 2]),
      .clr_i    (clr[i]),
      .level_o  (level[i]),
      .pulse_o  (pulse[i]),
      .pending_o(pending[i])
    );
  end

  // Interrupt is a plain OR of registered pending flags, adding no latency
  always_comb begin
    irq = |pending;
  end

endmodule
